// File: rtl/sext_block_accum.sv
// sext_block_accum: sign-extends stream samples and emits per-block sums with a signed-overflow flag
module sign_ext_gen #(
  parameter int FROM_WIDTH = 12,
  parameter int TO_WIDTH = 32
) (
  input logic [FROM_WIDTH-1:0] din,
  output logic [TO_WIDTH-1:0] dout
);
  assign dout = {{(TO_WIDTH-FROM_WIDTH){din[FROM_WIDTH-1]}}, din};
endmodule

module sext_block_accum #(
  parameter int FROM_WIDTH = 12,
  parameter int TO_WIDTH = 32,
  parameter int BLOCK_LEN = 4
) (
  input logic clk,
  input logic rst_n,
  input logic [FROM_WIDTH-1:0] in_data,
  input logic in_valid,
  output logic in_ready,
  output logic [TO_WIDTH-1:0] out_sum,
  output logic out_ovf,
  output logic out_valid,
  input logic out_ready
);
  localparam int CW = BLOCK_LEN > 1 ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);
  logic [CW-1:0] cnt;
  logic [TO_WIDTH-1:0] acc, ext, sum;
  logic ovf_acc, ovf_step, last, fire;
  sign_ext_gen #(.FROM_WIDTH(FROM_WIDTH), .TO_WIDTH(TO_WIDTH)) u_sext (.din(in_data), .dout(ext));
  always_comb begin
    sum = acc + ext;
    ovf_step = (acc[TO_WIDTH-1] == ext[TO_WIDTH-1]) && (sum[TO_WIDTH-1] != acc[TO_WIDTH-1]);
    last = cnt == LAST;
    in_ready = !(out_valid && last);
    fire = in_valid && in_ready;
  end
  // a final accept can only happen with the output register empty, so load never races drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_valid <= 1'b0;
    end else if (fire && last) begin
      out_sum <= sum;
      out_ovf <= ovf_acc | ovf_step;
      out_valid <= 1'b1;
      acc <= '0;
      ovf_acc <= 1'b0;
      cnt <= '0;
    end else begin
      if (fire) begin
        acc <= sum;
        ovf_acc <= ovf_acc | ovf_step;
        cnt <= cnt + 1'b1;
      end
      if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sext_block_accum.sv
// tb_sext_block_accum: three configurations driven in lockstep, checked against an arithmetic block-sum model
module tb_sext_block_accum;
  localparam int TW[3] = '{32, 13, 32};
  localparam int BL[3] = '{4, 4, 1};
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [11:0] in_data = '0;
  logic rdy[3], vld[3], ovf[3];
  logic [31:0] s0, s2;
  logic [12:0] s1;
  int tests = 0, fails = 0;
  longint eq[3][$];
  longint acc_m[3];
  int n_m[3];
  bit ov_m[3];

  always #5 clk = ~clk;

  sext_block_accum #(.FROM_WIDTH(12), .TO_WIDTH(32), .BLOCK_LEN(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .out_sum(s0), .out_ovf(ovf[0]), .out_valid(vld[0]), .out_ready(out_ready));
  sext_block_accum #(.FROM_WIDTH(12), .TO_WIDTH(13), .BLOCK_LEN(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .out_sum(s1), .out_ovf(ovf[1]), .out_valid(vld[1]), .out_ready(out_ready));
  sext_block_accum #(.FROM_WIDTH(12), .TO_WIDTH(32), .BLOCK_LEN(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[2]),
    .out_sum(s2), .out_ovf(ovf[2]), .out_valid(vld[2]), .out_ready(out_ready));

  task automatic chk(string tag, longint obs, longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // observed result packed as {ovf, sum} with ovf at bit 40
  function automatic longint obs_of(int k);
    longint o;
    o = k == 0 ? longint'(s0) : k == 1 ? longint'(s1) : longint'(s2);
    return o | (longint'(ovf[k]) << 40);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      eq[k].delete();
      acc_m[k] = 0;
      n_m[k] = 0;
      ov_m[k] = 1'b0;
    end
  endfunction

  // signed arithmetic with explicit range test; wrap back into TW bits on overflow
  function automatic void model_accept(int k, logic [11:0] d);
    longint h, s;
    h = longint'(1) << (TW[k] - 1);
    s = acc_m[k] + longint'($signed(d));
    if (s >= h) begin s -= 2 * h; ov_m[k] = 1'b1; end
    else if (s < -h) begin s += 2 * h; ov_m[k] = 1'b1; end
    if (n_m[k] == BL[k] - 1) begin
      eq[k].push_back((ov_m[k] ? (longint'(1) << 40) : 0) | (s & (2 * h - 1)));
      acc_m[k] = 0;
      n_m[k] = 0;
      ov_m[k] = 1'b0;
    end else begin
      acc_m[k] = s;
      n_m[k]++;
    end
  endfunction

  task automatic step(bit v, logic [11:0] d, bit r);
    bit er;
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid%0d", k), longint'(vld[k]), longint'(eq[k].size() > 0));
      if (eq[k].size() > 0) chk($sformatf("result%0d", k), obs_of(k), eq[k][0]);
      er = !(eq[k].size() > 0 && n_m[k] == BL[k] - 1);
      chk($sformatf("in_ready%0d", k), longint'(rdy[k]), longint'(er));
      if (eq[k].size() > 0 && r) void'(eq[k].pop_front());
      if (v && er) model_accept(k, d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), longint'(vld[k]), 0);
      chk($sformatf("rst_result%0d", k), obs_of(k), 0);
    end
    model_clear();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] d;
    @(negedge clk);
    do_reset();
    // basic block
    step(1, 12'h001, 1); step(1, 12'h002, 1); step(1, 12'hFFF, 1); step(1, 12'h800, 1);
    chk("basic_valid", longint'(vld[0]), 1);
    chk("basic_sum", longint'(s0), 64'hFFFFF802);
    chk("basic_ovf", longint'(ovf[0]), 0);
    step(0, 12'h000, 1);
    chk("basic_drop", longint'(vld[0]), 0);
    // reset mid-block discards the partial block
    step(1, 12'h7FF, 1); step(1, 12'h7FF, 1);
    do_reset();
    repeat (4) step(1, 12'h7FF, 1);
    chk("rst_blk_sum", longint'(s0), 64'h1FFC);
    chk("rst_blk_ovf", longint'(ovf[0]), 0);
    chk("ovf13_sum", longint'(s1), 64'h1FFC);
    chk("ovf13_flag", longint'(ovf[1]), 1);
    step(1, 12'h7FF, 1); step(1, 12'h801, 1); step(1, 12'h000, 1); step(1, 12'h000, 1);
    chk("cancel13_sum", longint'(s1), 0);
    chk("cancel13_ovf", longint'(ovf[1]), 0);
    // backpressure
    do_reset();
    repeat (4) step(1, 12'h001, 0);
    repeat (3) step(1, 12'h002, 0);
    step(1, 12'h002, 0);
    chk("bp_stall", longint'(rdy[0]), 0);
    chk("bp_hold", longint'(s0), 4);
    step(1, 12'h002, 1);
    step(1, 12'h002, 1);
    chk("bp_blk2", longint'(s0), 8);
    // streaming
    do_reset();
    repeat (8) step(1, 12'h003, 1);
    chk("stream_sum", longint'(s0), 12);
    step(0, 12'h000, 1);
    // single-sample blocks
    do_reset();
    step(1, 12'h800, 1);
    chk("bl1_first", longint'(s2), 64'hFFFFF800);
    step(1, 12'h7FF, 1);
    step(1, 12'h7FF, 1);
    chk("bl1_second", longint'(s2), 64'h7FF);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) do_reset();
      case ($urandom_range(0, 4))
        0: d = 12'h7FF;
        1: d = 12'h800;
        default: d = 12'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sext_block_accum.md
Name: sext_block_accum

Overview:
- Consumer stage directly downstream of the sign extender.
- Takes FROM_WIDTH-bit two's-complement samples over a valid/ready stream and sign-extends them to TO_WIDTH using the existing sign_ext_gen instance.
- Sums each group of BLOCK_LEN samples and presents the TO_WIDTH block sum, with a signed-overflow flag, on a registered valid/ready output.
- Accumulation of the next block overlaps with a pending output, so throughput is one sample per cycle unless the output stalls.

Parameters:
- FROM_WIDTH, 12, input sample width (signed); must be >= 2.
- TO_WIDTH, 32, extended/accumulator width; must be > FROM_WIDTH.
- BLOCK_LEN, 4, samples per block; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  FROM_WIDTH  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  stage can accept a sample.
- out_sum  out  TO_WIDTH  signed block sum.
- out_ovf  out  1  signed overflow occurred inside this block.
- out_valid  out  1  out_sum/out_ovf valid.
- out_ready  in  1  downstream accepts the output.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle, including mid-block or with output pending):
  - acc=0, cnt=0, ovf_acc=0.
  - out_valid=0, out_sum=0, out_ovf=0.
  - A partial block is discarded; a pending output is dropped.
- Accept: a sample is taken on a rising edge where in_valid && in_ready.
- in_ready = !(out_valid && cnt == BLOCK_LEN-1).
  - in_ready stalls only when the accepted sample would complete a block while the output register is still occupied.
  - in_ready does not depend on out_ready, so there is no combinational path out_ready -> in_ready.
- Per accept:
  - ext = sign_ext(in_data) to TO_WIDTH.
  - sum = acc + ext, wrapping modulo 2^TO_WIDTH.
  - ovf_step = (acc MSB == ext MSB) && (sum MSB != acc MSB).
- Accept with cnt < BLOCK_LEN-1: acc<=sum, ovf_acc<=ovf_acc|ovf_step, cnt<=cnt+1.
- Accept with cnt == BLOCK_LEN-1 (final sample):
  - out_sum<=sum, out_ovf<=ovf_acc|ovf_step, out_valid<=1.
  - acc<=0, ovf_acc<=0, cnt<=0.
- BLOCK_LEN=1: every accept is a final sample.
- Latency: out_valid rises on the edge that accepts the final sample and is visible in the following cycle.
- Output register states:
  - EMPTY (out_valid=0) -> FULL on final-sample accept.
  - FULL, out_ready=1, no final accept -> EMPTY.
  - FULL, out_ready=0 -> holds; out_sum/out_ovf stable while out_valid && !out_ready.
  - A final accept cannot occur in FULL (in_ready=0), so there is no load/drain conflict. Cost: a block completing while FULL is delayed one cycle even when out_ready=1 in that cycle.
- cnt width is clog2(BLOCK_LEN), minimum 1 bit; cnt never exceeds BLOCK_LEN-1.
- in_data is ignored when in_valid=0 or in_ready=0.
- Overflow is flagged per step: an intermediate overflow that later cancels still sets out_ovf.

Test Plan (FROM_WIDTH=12, TO_WIDTH=32, BLOCK_LEN=4 unless stated):
- Basic: samples 0x001, 0x002, 0xFFF, 0x800, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sum=0xFFFFF802 (-2046), out_ovf=0; out_valid=0 the next cycle.
- Reset mid-block: accept 0x7FF twice, pulse rst_n low between clock edges -> out_valid=0 immediately; then 4×0x7FF -> out_sum=0x00001FFC, out_ovf=0 (partial block discarded).
- Backpressure: out_ready=0. Block 1 = 4×0x001 -> out_sum=0x00000004 held. Feed 4×0x002 -> the 4th is stalled (in_ready=0) until out_ready=1. Block 1 drains that cycle; the 4th sample is accepted the next cycle; block 2 out_sum=0x00000008.
- Streaming: 8 consecutive samples of 0x003, in_valid=1, out_ready=1 -> in_ready never low; out_valid high for exactly 1 cycle after the 4th and after the 8th accept, out_sum=0x0000000C each time.
- Overflow (TO_WIDTH=13): 4×0x7FF -> out_sum=0x1FFC (-4 signed), out_ovf=1. Next block 0x7FF, 0x801, 0, 0 -> out_sum=0, out_ovf=0.
- BLOCK_LEN=1: samples 0x800, 0x7FF back-to-back, out_ready=1 -> in_ready drops for 1 cycle between them; outputs 0xFFFFF800 then 0x000007FF.
